// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write-port scheduler.
package rf_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  typedef enum logic {GNT_EX, GNT_LD} gnt_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves to the loser only when
// both requesters contend in an enabled cycle.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  gnt_t ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= GNT_EX;
    end else if (en && (&req)) begin
      ptr <= (ptr == GNT_EX) ? GNT_LD : GNT_EX;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) gnt = (ptr == GNT_EX) ? 2'b01 : 2'b10;
      else      gnt = req;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port scheduler: clears x1..x(NREG-1) after reset, then
// shares the write port between ALU writeback and load return.
//
// state    | meaning
// ST_CLEAR | one zero write per cycle to x1..x(NREG-1), requesters stalled
// ST_RUN   | round-robin between ex and ld, one write per cycle
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN           = rf_pkg::XLEN,
  parameter int NREG           = rf_pkg::NREG,
  parameter int AW             = rf_pkg::REG_AW,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [AW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            RegWEn,
  output logic [AW-1:0]   AddrD,
  output logic [XLEN-1:0] DataD,
  output logic            init_done
);

  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt;
  logic            run_en;
  logic [1:0]      gnt;
  logic            hs;
  logic [AW-1:0]   wr_rd;
  logic [XLEN-1:0] wr_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RST_STATE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && cnt == AW'(NREG - 1)) state_nxt = ST_RUN;
  end

  // Gating with rst keeps ready and init_done low while reset is held, even
  // when the reset state is already ST_RUN.
  always_comb begin
    run_en    = rst && (state == ST_RUN);
    init_done = run_en;
    ex_ready  = gnt[0];
    ld_ready  = gnt[1];
  end

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({ld_valid, ex_valid}),
    .en  (run_en),
    .gnt (gnt)
  );

  assign hs      = |gnt;
  assign wr_rd   = gnt[1] ? ld_rd   : ex_rd;
  assign wr_data = gnt[1] ? ld_data : ex_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWEn <= 1'b0;
      AddrD  <= '0;
      DataD  <= '0;
      cnt    <= AW'(1);
    end else if (state == ST_CLEAR) begin
      RegWEn <= 1'b1;
      AddrD  <= cnt;
      DataD  <= '0;
      cnt    <= cnt + AW'(1);
    end else if (hs) begin
      // x0 is hardwired: the request is consumed but never written
      RegWEn <= |wr_rd;
      AddrD  <= wr_rd;
      DataD  <= wr_data;
    end else begin
      RegWEn <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: clear sequence, arbitration table,
// mid-clear reset and the no-clear variant.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rst0;
  logic        ex_valid, ld_valid;
  logic [4:0]  ex_rd, ld_rd;
  logic [31:0] ex_data, ld_data;

  logic        ex_ready, ld_ready, RegWEn, init_done;
  logic [4:0]  AddrD;
  logic [31:0] DataD;
  logic        ex_ready0, ld_ready0, RegWEn0, init_done0;
  logic [4:0]  AddrD0;
  logic [31:0] DataD0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .RegWEn(RegWEn), .AddrD(AddrD), .DataD(DataD), .init_done(init_done)
  );

  regfile_wb_arbiter #(.CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .rst(rst0),
    .ex_valid(ex_valid), .ex_ready(ex_ready0), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready0), .ld_rd(ld_rd), .ld_data(ld_data),
    .RegWEn(RegWEn0), .AddrD(AddrD0), .DataD(DataD0), .init_done(init_done0)
  );

  typedef struct {
    logic        exv;
    logic [4:0]  exrd;
    logic [31:0] exd;
    logic        ldv;
    logic [4:0]  ldrd;
    logic [31:0] ldd;
    logic        er;
    logic        lr;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic apply(input int i, input vec_t v);
    @(negedge clk);
    ex_valid = v.exv; ex_rd = v.exrd; ex_data = v.exd;
    ld_valid = v.ldv; ld_rd = v.ldrd; ld_data = v.ldd;
    #1;
    chk($sformatf("v%0d ex_ready", i), 32'(ex_ready), 32'(v.er));
    chk($sformatf("v%0d ld_ready", i), 32'(ld_ready), 32'(v.lr));
    @(posedge clk); #1;
    chk($sformatf("v%0d RegWEn", i), 32'(RegWEn), 32'(v.we));
    chk($sformatf("v%0d AddrD", i), 32'(AddrD), 32'(v.addr));
    chk($sformatf("v%0d DataD", i), DataD, v.data);
  endtask

  initial begin
    //               exv exrd exd           ldv ldrd ldd          er lr we addr data
    tbl[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 1'b0, 5'd31, 32'h0};
    tbl[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    tbl[2]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd7, 32'h77,     1'b1, 1'b0, 1'b1, 5'd3,  32'h33};
    tbl[3]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd7, 32'h77,     1'b0, 1'b1, 1'b1, 5'd7,  32'h77};
    tbl[4]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd7, 32'h77,     1'b1, 1'b0, 1'b1, 5'd3,  32'h33};
    tbl[5]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd7, 32'h77,     1'b0, 1'b1, 1'b1, 5'd7,  32'h77};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'h1234,   1'b0, 1'b1, 1'b0, 5'd0,  32'h1234};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,      1'b0, 1'b0, 1'b0, 5'd0,  32'h1234};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 32'hA5A5,   1'b0, 1'b1, 1'b1, 5'd9,  32'hA5A5};
    tbl[9]  = '{1'b1, 5'd3,  32'h1,        1'b1, 5'd3, 32'h2,      1'b1, 1'b0, 1'b1, 5'd3,  32'h1};
    tbl[10] = '{1'b1, 5'd3,  32'h1,        1'b1, 5'd3, 32'h2,      1'b0, 1'b1, 1'b1, 5'd3,  32'h2};
    tbl[11] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,      1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF};
    tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1, 32'hCAFE,   1'b0, 1'b1, 1'b1, 5'd1,  32'hCAFE};
    tbl[13] = '{1'b1, 5'd2,  32'h22,       1'b1, 5'd6, 32'h66,     1'b1, 1'b0, 1'b1, 5'd2,  32'h22};
    tbl[14] = '{1'b1, 5'd2,  32'h22,       1'b1, 5'd6, 32'h66,     1'b0, 1'b1, 1'b1, 5'd6,  32'h66};

    rst = 1'b0; rst0 = 1'b0;
    ex_valid = 1'b1; ex_rd = 5'd4; ex_data = 32'h44;
    ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 32'h88;
    #2;
    chk("rst RegWEn", 32'(RegWEn), 32'd0);
    chk("rst AddrD", 32'(AddrD), 32'd0);
    chk("rst DataD", DataD, 32'd0);
    chk("rst init_done", 32'(init_done), 32'd0);
    chk("rst ex_ready", 32'(ex_ready), 32'd0);
    chk("rst ld_ready", 32'(ld_ready), 32'd0);
    chk("rst0 init_done", 32'(init_done0), 32'd0);
    chk("rst0 ex_ready", 32'(ex_ready0), 32'd0);

    // Clear sequence with both requesters pushing: they must be held off.
    @(negedge clk); rst = 1'b1;
    #1;
    chk("clr0 ex_ready", 32'(ex_ready), 32'd0);
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk); #1;
      chk($sformatf("clr%0d RegWEn", k), 32'(RegWEn), 32'd1);
      chk($sformatf("clr%0d AddrD", k), 32'(AddrD), 32'(k));
      chk($sformatf("clr%0d DataD", k), DataD, 32'd0);
      chk($sformatf("clr%0d init_done", k), 32'(init_done), (k == 31) ? 32'd1 : 32'd0);
      if (k < 31) begin
        chk($sformatf("clr%0d ex_ready", k), 32'(ex_ready), 32'd0);
        chk($sformatf("clr%0d ld_ready", k), 32'(ld_ready), 32'd0);
      end
    end
    ex_valid = 1'b0; ld_valid = 1'b0;

    for (int i = 0; i < 15; i++) apply(i, tbl[i]);

    // Reset mid-clear at count 10, then restart from x1.
    @(negedge clk);
    ex_valid = 1'b0; ld_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      chk($sformatf("mid%0d AddrD", k), 32'(AddrD), 32'(k));
    end
    @(negedge clk); rst = 1'b0;
    #1;
    chk("mid rst RegWEn", 32'(RegWEn), 32'd0);
    chk("mid rst AddrD", 32'(AddrD), 32'd0);
    chk("mid rst DataD", DataD, 32'd0);
    chk("mid rst init_done", 32'(init_done), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("restart RegWEn", 32'(RegWEn), 32'd1);
    chk("restart AddrD", 32'(AddrD), 32'd1);
    chk("restart init_done", 32'(init_done), 32'd0);

    // No-clear variant: usable on the first cycle after release.
    @(negedge clk);
    rst0 = 1'b1;
    ex_valid = 1'b1; ex_rd = 5'd12; ex_data = 32'hBEEF;
    ld_valid = 1'b0;
    #1;
    chk("nc init_done", 32'(init_done0), 32'd1);
    chk("nc ex_ready", 32'(ex_ready0), 32'd1);
    chk("nc ld_ready", 32'(ld_ready0), 32'd0);
    @(posedge clk); #1;
    chk("nc RegWEn", 32'(RegWEn0), 32'd1);
    chk("nc AddrD", 32'(AddrD0), 32'd12);
    chk("nc DataD", DataD0, 32'hBEEF);
    ex_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
